// File: rtl/alu_sequencer.sv
// Sequencer that feeds an external 8-bit ALU from an 8x8 register file: load-immediate or READ/EXEC/WB ops.
// Optional "zero" result flag output is built only when ALU_SEQ_ZERO_FLAG_EN is defined.
module alu_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_ld,
    input  logic [3:0] cmd_op,
    input  logic [2:0] cmd_dst,
    input  logic [2:0] cmd_srca,
    input  logic [2:0] cmd_srcb,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] result
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic       zero
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 32'd1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0][7:0] regs_q, regs_d;
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [7:0]      result_q, result_d;
    logic            done_q, done_d;
    logic [2:0]      dst_q, dst_d;
    logic [2:0]      srca_q, srca_d;
    logic [2:0]      srcb_q, srcb_d;
    logic [3:0]      op_q, op_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic            zero_q, zero_d;
    assign zero = zero_q;
`endif

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rd_data   = regs_q[rd_addr];

    // Next-state, register-file and output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        regs_d   = regs_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        done_d   = 1'b0;
        dst_d    = dst_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        op_d     = op_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_ld) begin
                        regs_d[cmd_dst] = cmd_imm;
                        result_d        = cmd_imm;
                        done_d          = 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        zero_d          = (cmd_imm == 8'h00);
`endif
                    end else begin
                        dst_d   = cmd_dst;
                        srca_d  = cmd_srca;
                        srcb_d  = cmd_srcb;
                        op_d    = cmd_op;
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                // Operands are captured here, before any writeback, so dst may alias a source.
                alu_a_d  = regs_q[srca_q];
                alu_b_d  = regs_q[srcb_q];
                alu_op_d = op_q;
                cnt_d    = 4'd0;
                state_d  = EXEC;
            end
            EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WB: begin
                regs_d[dst_q] = alu_out;
                result_d      = alu_out;
                done_d        = 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                zero_d        = (alu_out == 8'h00);
`endif
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            regs_q   <= '0;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= 4'd0;
            result_q <= 8'h00;
            done_q   <= 1'b0;
            dst_q    <= 3'd0;
            srca_q   <= 3'd0;
            srcb_q   <= 3'd0;
            op_q     <= 4'd0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            regs_q   <= regs_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            done_q   <= done_d;
            dst_q    <= dst_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            op_q     <= op_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: EXEC_CYCLES, default 1, number of cycles alu_out settles before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_ld  input  1  1 = load immediate, 0 = ALU operation.
REQ-007 cmd_op  input  4  ALU opcode: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not, 8 pass-a, 9 pass-b, 10 shl, 11 srl, 12 sra, 13 inc4, 14 dec4, 15 hamming weight.
REQ-008 cmd_dst / cmd_srca / cmd_srcb  input  3 each  destination and source register indices.
REQ-009 cmd_imm  input  8  immediate for loads.
REQ-010 alu_a, alu_b  output  8 each  registered operands to the external 8-bit ALU.
REQ-011 alu_op  output  4  registered opcode to the ALU.
REQ-012 alu_out  input  8  ALU result.
REQ-013 rd_addr  input  3 / rd_data  output  8  combinational debug read of the register file.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse: command completed.
REQ-016 result  output  8  last written value, held until the next completion.

Function
REQ-017 Storage: eight 8-bit registers r0..r7, all general purpose.
REQ-018 FSM states: IDLE, READ, EXEC, WB; cmd_ready SHALL equal (state==IDLE) and rst deasserted.
REQ-019 Accept edge E0 = rising edge with cmd_valid & cmd_ready; all cmd_* fields latched at E0.
REQ-020 Load (cmd_ld=1): at E0 r[dst]<=cmd_imm and result<=cmd_imm; done=1 for the cycle after E0; state stays IDLE.
REQ-021 ALU op: E0 IDLE->READ; at E1 alu_a<=r[srca], alu_b<=r[srcb], alu_op<=op, ->EXEC.
REQ-022 EXEC lasts exactly EXEC_CYCLES cycles (4-bit counter), then ->WB.
REQ-023 At WB edge: r[dst]<=alu_out, result<=alu_out, done<=1, ->IDLE; done high exactly the cycle after E(2+EXEC_CYCLES).
REQ-024 Unary ops (7, 8, 13, 14, 15) still drive alu_b from r[srcb]; the ALU ignores it.
REQ-025 dst equal to srca or srcb is legal; operands are latched before writeback.
REQ-026 A new command MAY be accepted in the done cycle (back-to-back, no bubble).
REQ-027 rd_data reflects a write in the cycle after the write edge; same-cycle reads return the old value.
REQ-028 cmd_valid while busy: the command is not taken; the requester holds fields stable until cmd_ready.

Reset
REQ-029 rst SHALL force: state IDLE, r0..r7=0, alu_a=alu_b=0, alu_op=0, result=0, done=0, busy=0, cmd_ready=0 while asserted, EXEC counter=0.
REQ-030 rst mid-operation SHALL abort without writeback or done pulse; cmd_ready rises the cycle after rst falls.

Configuration
REQ-031 Macro ALU_SEQ_ZERO_FLAG_EN: when defined, add output zero (1 bit), reset 0, updated together with result to (written value==8'h00), for loads and ALU ops alike; when undefined, the port and its logic are absent and all other behaviour is identical.

Verification
REQ-032 Loads r1<=8'h0F, then r2<=8'h03 -> done pulses the cycle after each accept; rd_addr=1 gives 8'h0F.
REQ-033 Add r3=r1+r2 with EXEC_CYCLES=1 -> busy for 3 cycles, then done with result=8'h12 and r3=8'h12.
REQ-034 Mul r1=r1*r2 (dst=srca) -> result=8'h2D; alu_a observed as 8'h0F during EXEC.
REQ-035 cmd_valid held with two queued commands -> second accepted in the first's done cycle; no idle gap.
REQ-036 rst pulsed during EXEC of a sub into r4 -> r4 stays 0, no done pulse, cmd_ready=1 the cycle after release.
REQ-037 With ALU_SEQ_ZERO_FLAG_EN: sub r5=r1-r1 -> result=8'h00, zero=1; then add r5=r1+r2 -> zero=0.
